// File: rtl/rect_stream_dma_if.sv
`default_nettype none
// ============================================================================
// Module : rect_stream_dma_if
// Brief  : Memory read port and GPU word stream of the rectangle DMA engine.
// Rev    : 1.0  initial release
// ============================================================================
interface rect_stream_dma_if #(
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] mem_din_addr;
   logic [15:0]           mem_din;
   logic [15:0]           out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;

   modport master (
      output mem_din_addr,
      input  mem_din,
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  mem_din_addr,
      output mem_din,
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface
`default_nettype wire

// File: rtl/rect_stream_dma.sv
`default_nettype none
// ============================================================================
// Module : rect_stream_dma
// Brief  : Walks a table of 6-word rect records and streams them to the GPU,
//          resolving relative coordinates and skipping hidden rects.
// Rev    : 1.0  initial release
// ============================================================================
module rect_stream_dma #(
   parameter int COORD_WIDTH = 16,
   parameter int ADDR_WIDTH  = 16,
   parameter int RECT_ADDR   = 256,
   parameter int RECT_COUNT  = 64
) (
   input  wire logic          clk,
   input  wire logic          reset_n,
   input  wire logic          copy_start,
   rect_stream_dma_if.master  bus,
   output logic               busy,
   output logic               done
);

   localparam int                    c_IDX_W    = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1;
   localparam logic [c_IDX_W-1:0]    c_LAST_IDX = c_IDX_W'(RECT_COUNT - 1);
   localparam logic [c_IDX_W-1:0]    c_IDX_ONE  = c_IDX_W'(1);
   localparam logic [ADDR_WIDTH-1:0] c_BASE     = ADDR_WIDTH'(RECT_ADDR);
   localparam logic [ADDR_WIDTH-1:0] c_ONE      = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] c_SKIP     = ADDR_WIDTH'(4);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_X    = 3'd2,
      S_Y    = 3'd3,
      S_W    = 3'd4,
      S_H    = 3'd5,
      S_C    = 3'd6,
      S_DONE = 3'd7
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0]  r_addr, w_addr_nxt;
   logic [c_IDX_W-1:0]     r_idx, w_idx_nxt;
   logic [COORD_WIDTH-1:0] r_cur_x, r_cur_y, w_cur_x_nxt, w_cur_y_nxt;
   logic                   r_abs, r_hidden, w_abs_nxt, w_hidden_nxt;
   logic                   w_end_rec;
   logic [COORD_WIDTH-1:0] w_mem_coord, w_rel_x, w_rel_y;

   // Relative sums wrap naturally at COORD_WIDTH bits.
   assign w_mem_coord      = bus.mem_din[COORD_WIDTH-1:0];
   assign w_rel_x          = r_cur_x + w_mem_coord;
   assign w_rel_y          = r_cur_y + w_mem_coord;
   assign bus.mem_din_addr = r_addr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_addr   <= c_BASE;
         r_idx    <= '0;
         r_cur_x  <= '0;
         r_cur_y  <= '0;
         r_abs    <= 1'b0;
         r_hidden <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_addr   <= w_addr_nxt;
         r_idx    <= w_idx_nxt;
         r_cur_x  <= w_cur_x_nxt;
         r_cur_y  <= w_cur_y_nxt;
         r_abs    <= w_abs_nxt;
         r_hidden <= w_hidden_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_addr_nxt    = r_addr;
      w_idx_nxt     = r_idx;
      w_cur_x_nxt   = r_cur_x;
      w_cur_y_nxt   = r_cur_y;
      w_abs_nxt     = r_abs;
      w_hidden_nxt  = r_hidden;
      w_end_rec     = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      bus.out_last  = 1'b0;
      busy          = 1'b1;
      done          = 1'b0;

      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (copy_start) begin
               w_state_nxt = S_HDR;
               w_cur_x_nxt = '0;
               w_cur_y_nxt = '0;
            end
         end
         S_HDR: begin
            bus.out_valid = !bus.mem_din[1];
            if (bus.mem_din[1] || bus.out_ready) begin
               w_abs_nxt    = bus.mem_din[0];
               w_hidden_nxt = bus.mem_din[1];
               w_addr_nxt   = r_addr + c_ONE;
               w_state_nxt  = S_X;
            end
         end
         S_X: begin
            bus.out_valid = !r_hidden;
            bus.out_data  = r_abs ? bus.mem_din : 16'(w_rel_x);
            if (r_hidden || bus.out_ready) begin
               if (r_abs) w_cur_x_nxt = w_mem_coord;
               w_addr_nxt  = r_addr + c_ONE;
               w_state_nxt = S_Y;
            end
         end
         S_Y: begin
            bus.out_valid = !r_hidden;
            bus.out_data  = r_abs ? bus.mem_din : 16'(w_rel_y);
            if (r_hidden || bus.out_ready) begin
               if (r_abs) w_cur_y_nxt = w_mem_coord;
               // Hidden rect: jump over W/H/C straight to the next header.
               if (r_hidden) begin
                  w_addr_nxt = r_addr + c_SKIP;
                  w_end_rec  = 1'b1;
               end else begin
                  w_addr_nxt  = r_addr + c_ONE;
                  w_state_nxt = S_W;
               end
            end
         end
         S_W, S_H: begin
            bus.out_valid = 1'b1;
            bus.out_data  = 16'(w_mem_coord);
            if (bus.out_ready) begin
               w_addr_nxt  = r_addr + c_ONE;
               w_state_nxt = (r_state == S_W) ? S_H : S_C;
            end
         end
         S_C: begin
            bus.out_valid = 1'b1;
            bus.out_data  = bus.mem_din;
            bus.out_last  = (r_idx == c_LAST_IDX);
            if (bus.out_ready) begin
               w_addr_nxt = r_addr + c_ONE;
               w_end_rec  = 1'b1;
            end
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
            w_addr_nxt  = c_BASE;
            w_idx_nxt   = '0;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_end_rec) begin
         if (r_idx == c_LAST_IDX) begin
            w_state_nxt = S_DONE;
         end else begin
            w_idx_nxt   = r_idx + c_IDX_ONE;
            w_state_nxt = S_HDR;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rect_stream_dma.sv
`default_nettype none
// ============================================================================
// Module : tb_rect_stream_dma
// Brief  : Self-checking bench for rect_stream_dma against a word-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rect_stream_dma;
   localparam int CW   = 10;
   localparam int AW   = 8;
   localparam int RA   = 16;
   localparam int RC   = 2;
   localparam int MAXC = 400;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic copy_start = 1'b0;
   logic busy, done;
   logic [15:0] mem [0:255];

   rect_stream_dma_if #(.ADDR_WIDTH(AW)) bus ();
   assign bus.mem_din = mem[bus.mem_din_addr];

   rect_stream_dma #(
      .COORD_WIDTH(CW), .ADDR_WIDTH(AW), .RECT_ADDR(RA), .RECT_COUNT(RC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .copy_start(copy_start),
      .bus(bus), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   bit          rdy_pat [0:MAXC-1];
   logic [15:0] exp_data [$];
   logic [15:0] got_data [$];
   bit          got_last [$];
   int          done_cyc;

   task automatic set_rect(input int i, input logic [15:0] f, x, y, w, h, c);
      mem[RA+6*i]   = f; mem[RA+6*i+1] = x; mem[RA+6*i+2] = y;
      mem[RA+6*i+3] = w; mem[RA+6*i+4] = h; mem[RA+6*i+5] = c;
   endtask

   task automatic ready_all;
      for (int k = 0; k < MAXC; k++) rdy_pat[k] = 1'b1;
   endtask

   // Word-level reference: expected stream and the cycle (counted from the
   // first cycle after copy_start is taken) on which done must appear.
   function automatic void model_frame(output int exp_cyc, output bit last_vis);
      int cx = 0, cy = 0, t = 0, mask = (1 << CW) - 1;
      exp_data.delete();
      last_vis = 1'b0;
      for (int i = 0; i < RC; i++) begin
         int b = RA + 6*i;
         logic [15:0] f = mem[b], x = mem[b+1], y = mem[b+2];
         logic [15:0] ex, ey;
         if (f[0]) begin
            ex = x; ey = y;
            cx = int'(x) & mask; cy = int'(y) & mask;
         end else begin
            ex = 16'((cx + (int'(x) & mask)) & mask);
            ey = 16'((cy + (int'(y) & mask)) & mask);
         end
         if (f[1]) begin
            t += 3;
            last_vis = 1'b0;
         end else begin
            exp_data.push_back(16'h0);
            exp_data.push_back(ex);
            exp_data.push_back(ey);
            exp_data.push_back(16'(int'(mem[b+3]) & mask));
            exp_data.push_back(16'(int'(mem[b+4]) & mask));
            exp_data.push_back(mem[b+5]);
            for (int j = 0; j < 6; j++) begin
               while (t < MAXC && !rdy_pat[t]) t++;
               t++;
            end
            last_vis = 1'b1;
         end
      end
      exp_cyc = t;
   endfunction

   task automatic run_frame(input bit spam);
      int exp_cyc;
      bit last_vis, stalled, want_last;
      logic [15:0] pd;
      logic [AW-1:0] pa;
      model_frame(exp_cyc, last_vis);
      got_data.delete(); got_last.delete();
      done_cyc = -1; stalled = 1'b0; pd = '0; pa = '0;
      @(posedge clk); #1; copy_start = 1'b1;
      for (int k = 0; k < MAXC; k++) begin
         @(posedge clk); #1;
         copy_start    = spam ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.out_ready = rdy_pat[k];
         #1;
         n_cmp++;
         if (busy !== 1'b1) begin
            n_err++; $display("FAIL busy_in_frame cyc %0d: got %b want 1", k, busy);
         end
         if (stalled) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== pd || bus.mem_din_addr !== pa) begin
               n_err++;
               $display("FAIL stall_hold cyc %0d: got v=%b d=%h a=%h want v=1 d=%h a=%h",
                        k, bus.out_valid, bus.out_data, bus.mem_din_addr, pd, pa);
            end
         end
         stalled = (bus.out_valid === 1'b1) && !bus.out_ready;
         pd = bus.out_data; pa = bus.mem_din_addr;
         if (bus.out_valid === 1'b1 && bus.out_ready) begin
            got_data.push_back(bus.out_data);
            got_last.push_back(bus.out_last === 1'b1);
         end
         if (done === 1'b1) begin
            done_cyc = k;
            break;
         end
      end
      n_cmp++;
      if (done_cyc != exp_cyc) begin
         n_err++; $display("FAIL frame_cycles: got %0d want %0d", done_cyc, exp_cyc);
      end
      @(posedge clk); #1; copy_start = 1'b0; bus.out_ready = 1'b1; #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || bus.mem_din_addr !== AW'(RA)) begin
         n_err++;
         $display("FAIL post_done: got busy=%b done=%b addr=%h want 0 0 %h",
                  busy, done, bus.mem_din_addr, AW'(RA));
      end
      n_cmp++;
      if (got_data.size() != exp_data.size()) begin
         n_err++; $display("FAIL stream_len: got %0d want %0d", got_data.size(), exp_data.size());
      end
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
         want_last = last_vis && (i == exp_data.size() - 1);
         n_cmp++;
         if (got_data[i] !== exp_data[i] || got_last[i] != want_last) begin
            n_err++;
            $display("FAIL stream_word %0d: got %h last=%b want %h last=%b",
                     i, got_data[i], got_last[i], exp_data[i], want_last);
         end
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== 16'h0 ||
          busy !== 1'b0 || done !== 1'b0 || bus.mem_din_addr !== AW'(RA)) begin
         n_err++;
         $display("FAIL reset_values: got v=%b l=%b d=%h busy=%b done=%b a=%h want 0 0 0 0 0 %h",
                  bus.out_valid, bus.out_last, bus.out_data, busy, done, bus.mem_din_addr, AW'(RA));
      end
      reset_n = 1'b1;
      set_rect(0, 16'h1, 16'd100, 16'd50, 16'd10, 16'd20, 16'hF800);
      set_rect(1, 16'h0, 16'd5, 16'd7, 16'd3, 16'd4, 16'h07E0);
      @(posedge clk); #1; copy_start = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1; copy_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b1 || bus.out_valid !== 1'b1) begin
         n_err++; $display("FAIL mid_frame_active: got busy=%b v=%b want 1 1", busy, bus.out_valid);
      end
      #2; reset_n = 1'b0; #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.mem_din_addr !== AW'(RA) ||
          done !== 1'b0 || bus.out_last !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: got v=%b busy=%b a=%h done=%b want 0 0 %h 0",
                  bus.out_valid, busy, bus.mem_din_addr, done, AW'(RA));
      end
      #1; reset_n = 1'b1;
      @(posedge clk); #2;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL idle_after_reset: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_basic;
      logic [15:0] ref_w [12] = '{16'h0, 16'd100, 16'd50, 16'd10, 16'd20, 16'hF800,
                                  16'h0, 16'd105, 16'd57, 16'd3, 16'd4, 16'h07E0};
      set_rect(0, 16'h1, 16'd100, 16'd50, 16'd10, 16'd20, 16'hF800);
      set_rect(1, 16'h0, 16'd5, 16'd7, 16'd3, 16'd4, 16'h07E0);
      ready_all();
      run_frame(1'b0);
      n_cmp++;
      if (done_cyc != 12) begin
         n_err++; $display("FAIL basic_latency: got %0d want 12", done_cyc);
      end
      for (int i = 0; i < 12 && i < got_data.size(); i++) begin
         n_cmp++;
         if (got_data[i] !== ref_w[i]) begin
            n_err++; $display("FAIL basic_word %0d: got %h want %h", i, got_data[i], ref_w[i]);
         end
      end
   endtask

   task automatic test_wrap;
      set_rect(0, 16'h1, 16'd1020, 16'd3, 16'd1, 16'd1, 16'h1234);
      set_rect(1, 16'h0, 16'd10, 16'd2, 16'd1, 16'd1, 16'h5678);
      ready_all();
      run_frame(1'b0);
      n_cmp++;
      if (got_data.size() < 8 || got_data[7] !== 16'd6) begin
         n_err++;
         $display("FAIL wrap_x: got %h want 0006", (got_data.size() >= 8) ? got_data[7] : 16'hxxxx);
      end
   endtask

   task automatic test_backpressure;
      set_rect(0, 16'h1, 16'd100, 16'd50, 16'd10, 16'd20, 16'hF800);
      set_rect(1, 16'h0, 16'd5, 16'd7, 16'd3, 16'd4, 16'h07E0);
      ready_all();
      for (int k = 3; k < 6; k++) rdy_pat[k] = 1'b0;
      run_frame(1'b0);
      n_cmp++;
      if (done_cyc != 15 || got_data.size() < 4 || got_data[3] !== 16'd10) begin
         n_err++;
         $display("FAIL backpressure: got cycles=%0d words=%0d want cycles=15 w3=000a",
                  done_cyc, got_data.size());
      end
   endtask

   task automatic test_hidden;
      set_rect(0, 16'h3, 16'd200, 16'd80, 16'd9, 16'd9, 16'hAAAA);
      set_rect(1, 16'h0, 16'd1, 16'd2, 16'd3, 16'd4, 16'h0F0F);
      ready_all();
      run_frame(1'b0);
      n_cmp++;
      if (done_cyc != 9 || got_data.size() != 6 || got_data[1] !== 16'd201 || got_data[2] !== 16'd82) begin
         n_err++;
         $display("FAIL hidden: got cycles=%0d words=%0d want cycles=9 words=6 x=201 y=82",
                  done_cyc, got_data.size());
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] first [$];
      set_rect(0, 16'h0, 16'd30, 16'd40, 16'd5, 16'd6, 16'h1111);
      set_rect(1, 16'h1, 16'd500, 16'd600, 16'd7, 16'd8, 16'h2222);
      ready_all();
      run_frame(1'b1);
      first = got_data;
      run_frame(1'b1);
      n_cmp++;
      if (got_data != first || got_data.size() < 2 || got_data[1] !== 16'd30) begin
         n_err++;
         $display("FAIL back_to_back: got words=%0d want identical frame with x=001e", got_data.size());
      end
   endtask

   task automatic test_random;
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < RC; i++)
            set_rect(i, 16'($urandom), 16'($urandom), 16'($urandom),
                     16'($urandom), 16'($urandom), 16'($urandom));
         for (int k = 0; k < MAXC; k++) rdy_pat[k] = ($urandom_range(0, 9) < 7);
         run_frame(1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 16'h0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_hidden();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
